// File: rtl/topk_merge_16.sv
// topk_merge_16
// Streaming top-16 accumulator. Accepts descending-sorted 16-element blocks
// that make up one frame and keeps the 16 largest values seen so far. Each
// block after the first is merged into the running set with one max stage and
// four half-cleaner stages, one per cycle. The frame's last block releases the
// final descending top-16 vector through a valid/ready handshake.
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   valid_i  input block valid
//   ready_o  block can be accepted (state == IDLE)
//   first_i  block opens a new frame (sampled on handshake)
//   last_i   block closes the frame (sampled on handshake)
//   x_i      input block, descending (x_i[0] largest)
//   valid_o  result valid
//   ready_i  consumer accepts the result
//   y_o      running top-16, descending (y_o[0] largest)
//   cnt_o    blocks accepted in the current frame, saturating
module topk_merge_16 #(
   parameter int DATAWIDTH  = 8,
   parameter int DATALENGTH = 16,
   parameter int CNTWIDTH   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic                 first_i,
   input  logic                 last_i,
   input  logic [DATAWIDTH-1:0] x_i [DATALENGTH],
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DATAWIDTH-1:0] y_o [DATALENGTH],
   output logic [CNTWIDTH-1:0]  cnt_o
);

   typedef enum logic [2:0] {IDLE, M8, M4, M2, M1, OUT} state_t;

   state_t                state_reg, state_next;
   logic [DATAWIDTH-1:0]  acc_reg  [DATALENGTH];
   logic [DATAWIDTH-1:0]  acc_next [DATALENGTH];
   logic                  open_reg, open_next;
   logic                  pend_reg, pend_next;
   logic [CNTWIDTH-1:0]   cnt_reg,  cnt_next;

   // Max stage: pairing acc (descending) with the reversed block (ascending)
   // keeps the top 16 of the union and leaves a bitonic sequence.
   logic [DATAWIDTH-1:0]  merged [DATALENGTH];
   // Half-cleaner results for distances 8, 4, 2, 1 (index 0..3).
   logic [DATAWIDTH-1:0]  hc [4][DATALENGTH];

   genvar gi, si;
   generate
      for (gi = 0; gi < DATALENGTH; gi++) begin : g_max
         assign merged[gi] = (acc_reg[gi] >= x_i[DATALENGTH-1-gi]) ?
                             acc_reg[gi] : x_i[DATALENGTH-1-gi];
      end
      for (si = 0; si < 4; si++) begin : g_stage
         localparam int D = 8 >> si;
         for (gi = 0; gi < DATALENGTH; gi++) begin : g_elem
            if ((gi % (2 * D)) < D) begin : g_upper
               // Upper element of the pair keeps the larger value.
               assign hc[si][gi] = (acc_reg[gi] >= acc_reg[gi+D]) ?
                                   acc_reg[gi] : acc_reg[gi+D];
            end else begin : g_lower
               assign hc[si][gi] = (acc_reg[gi-D] >= acc_reg[gi]) ?
                                   acc_reg[gi] : acc_reg[gi-D];
            end
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      open_next  = open_reg;
      pend_next  = pend_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (valid_i) begin
               if (first_i || !open_reg) begin
                  // Input is already sorted, so a first block needs no merge.
                  acc_next   = x_i;
                  cnt_next   = CNTWIDTH'(1);
                  open_next  = 1'b1;
                  state_next = last_i ? OUT : IDLE;
               end else begin
                  acc_next   = merged;
                  cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
                  pend_next  = last_i;
                  state_next = M8;
               end
            end
         end
         M8: begin
            acc_next   = hc[0];
            state_next = M4;
         end
         M4: begin
            acc_next   = hc[1];
            state_next = M2;
         end
         M2: begin
            acc_next   = hc[2];
            state_next = M1;
         end
         M1: begin
            acc_next   = hc[3];
            state_next = pend_reg ? OUT : IDLE;
         end
         OUT: begin
            if (ready_i) begin
               state_next = IDLE;
               open_next  = 1'b0;
               pend_next  = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         acc_reg   <= '{default: '0};
         open_reg  <= 1'b0;
         pend_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         open_reg  <= open_next;
         pend_reg  <= pend_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign ready_o = (state_reg == IDLE);
   assign valid_o = (state_reg == OUT);
   assign y_o     = acc_reg;
   assign cnt_o   = cnt_reg;

endmodule

// File: tb/tb_topk_merge_16.sv
// Testbench for topk_merge_16: scenario tasks plus randomized frames, checked
// against a reference that keeps every value of the frame and sorts them.
module tb_topk_merge_16;

   typedef logic [7:0] vec_t [16];

   logic        clk = 1'b0;
   logic        rst_i, valid_i, first_i, last_i, ready_i;
   logic        ready_o, valid_o;
   vec_t        x_i, y_o;
   logic [15:0] cnt_o;

   int passed = 0;
   int total  = 0;

   int model_q[$];
   int model_cnt  = 0;
   bit model_open = 0;

   always #5 clk = ~clk;

   topk_merge_16 dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .first_i (first_i),
      .last_i  (last_i),
      .x_i     (x_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .y_o     (y_o),
      .cnt_o   (cnt_o)
   );

   function automatic logic [127:0] pack(input vec_t v);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = v[i];
      return r;
   endfunction

   // Top 16 of all values in the current frame, largest first.
   function automatic logic [127:0] model_top();
      int s[$];
      logic [127:0] r;
      s = model_q;
      s.rsort();
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = 8'(s[i]);
      return r;
   endfunction

   function automatic void model_accept(input vec_t v, input bit f);
      if (f || !model_open) begin
         model_q.delete();
         model_cnt  = 1;
         model_open = 1;
      end else begin
         model_cnt++;
      end
      for (int i = 0; i < 16; i++) model_q.push_back(int'(v[i]));
   endfunction

   function automatic vec_t rand_block(input int maxv);
      int s[$];
      vec_t v;
      for (int i = 0; i < 16; i++) s.push_back(int'($urandom_range(0, maxv)));
      s.rsort();
      for (int i = 0; i < 16; i++) v[i] = 8'(s[i]);
      return v;
   endfunction

   function automatic vec_t ramp(input int start, input int step);
      vec_t v;
      for (int i = 0; i < 16; i++) v[i] = 8'(start - step * i);
      return v;
   endfunction

   // Offer a block and hold it until the DUT takes it (bounded wait).
   task automatic send_block(input vec_t v, input bit f, input bit l);
      int n = 0;
      x_i = v; first_i = f; last_i = l; valid_i = 1'b1;
      while (!ready_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready_o) begin
         total++;
         $display("FAIL send_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, n);
         valid_i = 1'b0;
      end else begin
         @(posedge clk); #1;
         model_accept(v, f);
         valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
      end
   endtask

   // Cycles from the accepting edge until valid_o is seen (1 = next cycle).
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_o && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      model_open = 0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;
      x_i = '{default: '0};
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (valid_o !== 1'b0) $display("FAIL reset_valid: got %0b required 0", valid_o);
      else passed++;
      total++;
      if (ready_o !== 1'b1) $display("FAIL reset_ready: got %0b required 1", ready_o);
      else passed++;
      total++;
      if (pack(y_o) !== 128'h0) $display("FAIL reset_y: got %h required 0", pack(y_o));
      else passed++;
      total++;
      if (cnt_o !== 16'd0) $display("FAIL reset_cnt: got %0d required 0", cnt_o);
      else passed++;
      rst_i = 1'b0;
      @(posedge clk); #1;
      $display("tx reset: y=%h cnt=%0d", pack(y_o), cnt_o);
   endtask

   task automatic test_single();
      int lat;
      send_block(ramp(15, 1), 1'b1, 1'b1);
      wait_valid(lat);
      total++;
      if (lat != 1) $display("FAIL single_latency: got %0d required 1", lat);
      else passed++;
      total++;
      if (pack(y_o) !== model_top()) $display("FAIL single_y: got %h required %h", pack(y_o), model_top());
      else passed++;
      total++;
      if (cnt_o !== 16'd1) $display("FAIL single_cnt: got %0d required 1", cnt_o);
      else passed++;
      $display("tx single: y=%h cnt=%0d", pack(y_o), cnt_o);
      release_result();
      total++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1)
         $display("FAIL single_release: got valid=%0b ready=%0b required valid=0 ready=1", valid_o, ready_o);
      else passed++;
   endtask

   task automatic test_two_block();
      int lat;
      int lowc = 0;
      send_block(ramp(31, 2), 1'b1, 1'b0);
      total++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0)
         $display("FAIL two_first_idle: got ready=%0b valid=%0b required ready=1 valid=0", ready_o, valid_o);
      else passed++;
      send_block(ramp(30, 2), 1'b0, 1'b1);
      lat = 1;
      while (!valid_o && lat < 30) begin
         if (!ready_o) lowc++;
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lowc != 4) $display("FAIL two_ready_low: got %0d cycles required 4", lowc);
      else passed++;
      total++;
      if (lat != 5) $display("FAIL two_latency: got %0d required 5", lat);
      else passed++;
      total++;
      if (pack(y_o) !== model_top()) $display("FAIL two_y: got %h required %h", pack(y_o), model_top());
      else passed++;
      total++;
      if (cnt_o !== 16'd2) $display("FAIL two_cnt: got %0d required 2", cnt_o);
      else passed++;
      $display("tx two_block: y=%h cnt=%0d", pack(y_o), cnt_o);
      release_result();
   endtask

   task automatic test_dominance();
      int lat;
      for (int fr = 0; fr < 2; fr++) begin
         send_block(ramp(fr == 0 ? 100 : 50, 1), 1'b1, 1'b0);
         send_block(ramp(fr == 0 ? 50 : 200, 1), 1'b0, 1'b1);
         wait_valid(lat);
         total++;
         if (pack(y_o) !== model_top()) $display("FAIL dominance_y%0d: got %h required %h", fr, pack(y_o), model_top());
         else passed++;
         total++;
         if (cnt_o !== 16'(model_cnt)) $display("FAIL dominance_cnt%0d: got %0d required %0d", fr, cnt_o, model_cnt);
         else passed++;
         $display("tx dominance%0d: y=%h cnt=%0d", fr, pack(y_o), cnt_o);
         release_result();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit held = 1;
      logic [127:0] expv;
      send_block(rand_block(255), 1'b1, 1'b0);
      send_block(rand_block(255), 1'b0, 1'b1);
      wait_valid(lat);
      expv = model_top();
      ready_i = 1'b0;
      x_i = rand_block(255); first_i = 1'b1; last_i = 1'b1; valid_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (valid_o !== 1'b1 || ready_o !== 1'b0 || pack(y_o) !== expv || cnt_o !== 16'(model_cnt))
            held = 0;
         @(posedge clk); #1;
      end
      total++;
      if (!held) $display("FAIL bp_hold: got valid=%0b ready=%0b y=%h required valid=1 ready=0 y=%h", valid_o, ready_o, pack(y_o), expv);
      else passed++;
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0; valid_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
      model_open = 0;
      total++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1)
         $display("FAIL bp_release: got valid=%0b ready=%0b required valid=0 ready=1", valid_o, ready_o);
      else passed++;
      total++;
      if (cnt_o !== 16'(model_cnt) || pack(y_o) !== expv)
         $display("FAIL bp_no_consume: got cnt=%0d y=%h required cnt=%0d y=%h", cnt_o, pack(y_o), model_cnt, expv);
      else passed++;
      $display("tx backpressure: y=%h cnt=%0d", pack(y_o), cnt_o);
   endtask

   task automatic test_reset_mid_merge();
      int lat;
      send_block(rand_block(255), 1'b1, 1'b0);
      send_block(rand_block(255), 1'b0, 1'b1);
      @(posedge clk); #1;
      rst_i = 1'b1;
      #1;
      model_q.delete(); model_cnt = 0; model_open = 0;
      total++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || pack(y_o) !== 128'h0 || cnt_o !== 16'd0)
         $display("FAIL midrst_outputs: got valid=%0b ready=%0b y=%h cnt=%0d required 0 1 0 0", valid_o, ready_o, pack(y_o), cnt_o);
      else passed++;
      @(posedge clk); #1;
      rst_i = 1'b0;
      total++;
      if (ready_o !== 1'b1) $display("FAIL midrst_ready: got %0b required 1", ready_o);
      else passed++;
      send_block(rand_block(255), 1'b0, 1'b1);
      wait_valid(lat);
      total++;
      if (lat != 1) $display("FAIL midrst_first_latency: got %0d required 1", lat);
      else passed++;
      total++;
      if (pack(y_o) !== model_top() || cnt_o !== 16'd1)
         $display("FAIL midrst_first: got y=%h cnt=%0d required y=%h cnt=1", pack(y_o), cnt_o, model_top());
      else passed++;
      $display("tx reset_mid_merge: y=%h cnt=%0d", pack(y_o), cnt_o);
      release_result();
   endtask

   task automatic test_restart();
      int lat;
      vec_t ff;
      ff = '{default: 8'hFF};
      send_block(ff, 1'b1, 1'b0);
      send_block(ff, 1'b0, 1'b0);
      send_block(ff, 1'b1, 1'b1);
      wait_valid(lat);
      total++;
      if (lat != 1) $display("FAIL restart_latency: got %0d required 1", lat);
      else passed++;
      total++;
      if (cnt_o !== 16'd1) $display("FAIL restart_cnt: got %0d required 1", cnt_o);
      else passed++;
      total++;
      if (pack(y_o) !== {16{8'hFF}}) $display("FAIL restart_y: got %h required all ff", pack(y_o));
      else passed++;
      $display("tx restart: y=%h cnt=%0d", pack(y_o), cnt_o);
      release_result();
   endtask

   task automatic test_random();
      int lat, nblk, exp_lat;
      bit f, last_first;
      for (int fr = 0; fr < 20; fr++) begin
         nblk = int'($urandom_range(1, 5));
         last_first = 0;
         for (int b = 0; b < nblk; b++) begin
            if (b == 0) f = 1'($urandom_range(0, 1));
            else        f = ($urandom_range(0, 5) == 0);
            last_first = (b == 0) || f;
            send_block(rand_block($urandom_range(0, 1) ? 255 : 15), f, b == nblk - 1);
         end
         exp_lat = last_first ? 1 : 5;
         wait_valid(lat);
         total++;
         if (lat != exp_lat) $display("FAIL rand%0d_latency: got %0d required %0d", fr, lat, exp_lat);
         else passed++;
         total++;
         if (pack(y_o) !== model_top()) $display("FAIL rand%0d_y: got %h required %h", fr, pack(y_o), model_top());
         else passed++;
         total++;
         if (cnt_o !== 16'(model_cnt)) $display("FAIL rand%0d_cnt: got %0d required %0d", fr, cnt_o, model_cnt);
         else passed++;
         $display("tx random%0d: blocks=%0d y=%h cnt=%0d", fr, nblk, pack(y_o), cnt_o);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_block();
      test_dominance();
      test_backpressure();
      test_reset_mid_merge();
      test_restart();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
